tmnt_rom_server: RTL
====================

Name: tmnt_rom_server

Overview:
SDRAM-side responder for the four ROM fetch channels issued by the TMNT/MIA core: 68k program, tiles, sprites and theme/sample.
- Latches each channel's one-cycle request pulse and address, then arbitrates.
- Issues 32-bit reads to the SDRAM controller port.
- Returns data to the requesting channel and drives the core's sdram_dtack wait line.
- Sits between the tmnt core and the SDRAM controller in the MiSTer top level.

Parameters:
M68K_BASE, 26'h0000000, SDRAM byte base of 68k program ROM
TILES_BASE, 26'h0100000, SDRAM byte base of tile ROM
SPR_BASE, 26'h0200000, SDRAM byte base of sprite ROM
THEME_BASE, 26'h0400000, SDRAM byte base of theme/sample ROM

Ports:
clk_sys  in  1  96 MHz system clock
reset  in  1  asynchronous, active-high
load_en  in  1  HPS ROM download in progress; blocks grants
m68k_rom_req  in  1  one-cycle request pulse
m68k_rom_addr  in  18  68k word address
m68k_rom_dout  out  16  68k read data
sdram_dtack  out  1  high = 68k data ready; low = CPU must wait
tiles_rom_req  in  1  one-cycle request pulse
tiles_rom_addr  in  18  32-bit word address
tiles_rom_dout  out  32  tile data
spr_rom_req  in  1  one-cycle request pulse
spr_rom_addr  in  19  32-bit word address
spr_rom_dout  out  32  sprite data
theme_rom_req  in  1  one-cycle request pulse
theme_rom_addr  in  18  32-bit word address
theme_rom_dout  out  32  theme data
sd_req  out  1  read request to SDRAM controller
sd_addr  out  26  byte address, 32-bit aligned
sd_ack  in  1  one-cycle accept of sd_req
sd_valid  in  1  one-cycle read data strobe
sd_data  in  32  read data

Behaviour:
Reset values:
- All *_dout 0; sdram_dtack 1; sd_req 0; sd_addr 0.
- All pending flags clear; FSM IDLE.

Request capture:
- A req pulse sets that channel's pending flag and registers its address on the same edge.
- A new pulse while pending overwrites the address: latest wins; still a single fetch.
- A pulse arriving on the same edge the channel is granted is kept as a new pending request.

Address mapping:
- m68k: M68K_BASE + {addr[17:1], 2'b00}; addr[0] selects the half, 0 = sd_data[15:0], 1 = sd_data[31:16].
- tiles/spr/theme: BASE + {addr, 2'b00}.
- All sums truncated to 26 bits.

Arbitration:
- Fixed priority: tiles > spr > m68k > theme. Video channels have a hard 32-clock deadline.
- Evaluated only in IDLE with load_en low.

FSM:
- IDLE: if any pending flag is set and load_en is low → REQ. Latch the grant id, drive sd_addr, set sd_req, clear that pending flag.
- REQ: hold sd_req and sd_addr stable until sd_ack. On sd_ack, drop sd_req → WAIT.
- WAIT: on sd_valid, write the granted channel's dout register → IDLE.
- A sd_valid seen in IDLE or REQ is ignored.
- A new grant is possible in the cycle after sd_valid. Minimum service = 3 clocks plus SDRAM latency.

sdram_dtack:
- Combinational: sdram_dtack = ~(m68k_rom_req | m68k_pend | m68k_busy).
- m68k_busy is set from grant until the delivery edge.
- Drops in the same cycle as the request pulse; rises the cycle after m68k data is written.

Other rules:
- dout registers hold their value until the next delivery to that channel.
- load_en rising mid-transaction: the current transaction completes; no new grants until load_en falls. Pending flags are retained and sdram_dtack stays low while any m68k request is outstanding.
- Reset mid-operation clears everything asynchronously. A late sd_valid after reset is ignored because the FSM is in IDLE.

Optional Feature:
ROM_SRV_STATS_EN
- When defined, adds outputs stat_overrun[3:0] (sticky per channel; set when a req pulse hits an already-pending channel) and stat_maxlat (16 bits).
- stat_maxlat is the maximum number of clocks from any video req pulse to its delivery; it saturates at FFFF.
- Both are cleared by reset only.
- When undefined, these ports and registers are absent and behaviour is otherwise identical.

Test Plan:
1. m68k_rom_req with addr 18'h00003, M68K_BASE 0, sd_data 32'hBEEF_1234, ack/valid after 2 clocks → sd_addr 26'h000004; sdram_dtack low the same cycle as req; m68k_rom_dout 16'hBEEF; sdram_dtack high the cycle after valid.
2. tiles, spr, m68k and theme pulsed on the same edge → grants issued in the order tiles (TILES_BASE), spr, m68k, theme; each dout gets its own data; sdram_dtack low until the third delivery.
3. spr pulsed at addr 19'h00010 then 19'h00020 before grant (tiles busy) → exactly one spr fetch at SPR_BASE + 26'h80; with ROM_SRV_STATS_EN, stat_overrun[1] = 1.
4. load_en high, then theme pulse → no sd_req while load_en is high; after load_en falls, sd_req within 1 clock.
5. Reset asserted in WAIT, then sd_valid pulsed → dout stays 0, sdram_dtack 1, FSM IDLE, no sd_req.
6. Video pulses every 32 clocks, sd latency 10 clocks, m68k requests interleaved → every tiles/spr delivery within 32 clocks of its pulse; no m68k starvation beyond 64 clocks.

Source files
------------

// File: rtl/tmnt_rom_server.sv
// tmnt_rom_server: SDRAM-side responder for the four TMNT/MIA ROM fetch
// channels (68k program, tiles, sprites, theme/sample). Each channel's
// request pulse is latched into a pending flag and address register, a fixed
// priority arbiter picks one, and a small FSM issues a 32-bit SDRAM read and
// returns the word to the requesting channel's dout register.
// Optional build macro ROM_SRV_STATS_EN adds overrun and video latency stats.
module tmnt_rom_server #(
    parameter logic [25:0] M68K_BASE  = 26'h0000000,
    parameter logic [25:0] TILES_BASE = 26'h0100000,
    parameter logic [25:0] SPR_BASE   = 26'h0200000,
    parameter logic [25:0] THEME_BASE = 26'h0400000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        load_en,
    input  logic        m68k_rom_req,
    input  logic [17:0] m68k_rom_addr,
    output logic [15:0] m68k_rom_dout,
    output logic        sdram_dtack,
    input  logic        tiles_rom_req,
    input  logic [17:0] tiles_rom_addr,
    output logic [31:0] tiles_rom_dout,
    input  logic        spr_rom_req,
    input  logic [18:0] spr_rom_addr,
    output logic [31:0] spr_rom_dout,
    input  logic        theme_rom_req,
    input  logic [17:0] theme_rom_addr,
    output logic [31:0] theme_rom_dout,
`ifdef ROM_SRV_STATS_EN
    output logic [3:0]  stat_overrun,
    output logic [15:0] stat_maxlat,
`endif
    output logic        sd_req,
    output logic [25:0] sd_addr,
    input  logic        sd_ack,
    input  logic        sd_valid,
    input  logic [31:0] sd_data
);

    // Channel ids, also the priority order (lowest id wins).
    localparam logic [1:0] CH_TILES = 2'd0;
    localparam logic [1:0] CH_SPR   = 2'd1;
    localparam logic [1:0] CH_M68K  = 2'd2;
    localparam logic [1:0] CH_THEME = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t      state_q;
    logic [1:0]  gnt_q;
    logic        hi_q;
    logic        sd_req_q;
    logic [25:0] sd_addr_q;
    logic        m68k_busy_q;
    logic [15:0] m68k_dout_q;
    logic [31:0] tiles_dout_q, spr_dout_q, theme_dout_q;

    logic [3:0]  pend_q;
    logic [17:0] tiles_addr_q, m68k_addr_q, theme_addr_q;
    logic [18:0] spr_addr_q;

    logic [3:0]  req_v;
    logic [3:0]  gnt_clr;
    logic [1:0]  gnt_sel;
    logic [25:0] gnt_addr;
    logic        grant_fire;

    assign req_v      = {theme_rom_req, m68k_rom_req, spr_rom_req, tiles_rom_req};
    assign grant_fire = (state_q == S_IDLE) && !load_en && (pend_q != 4'd0);
    assign gnt_clr    = grant_fire ? (4'b0001 << gnt_sel) : 4'b0000;

    // Fixed-priority pick and SDRAM byte address of the winning channel.
    always_comb begin
        gnt_sel = CH_THEME;
        if (pend_q[CH_TILES])     gnt_sel = CH_TILES;
        else if (pend_q[CH_SPR])  gnt_sel = CH_SPR;
        else if (pend_q[CH_M68K]) gnt_sel = CH_M68K;
        case (gnt_sel)
            CH_TILES: gnt_addr = TILES_BASE + {6'd0, tiles_addr_q, 2'b00};
            CH_SPR:   gnt_addr = SPR_BASE   + {5'd0, spr_addr_q, 2'b00};
            CH_M68K:  gnt_addr = M68K_BASE  + {7'd0, m68k_addr_q[17:1], 2'b00};
            default:  gnt_addr = THEME_BASE + {6'd0, theme_addr_q, 2'b00};
        endcase
    end

    // Request capture: a pulse sets pending (surviving a same-edge grant) and latest address wins.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            pend_q       <= 4'd0;
            tiles_addr_q <= 18'd0;
            spr_addr_q   <= 19'd0;
            m68k_addr_q  <= 18'd0;
            theme_addr_q <= 18'd0;
        end else begin
            pend_q <= req_v | (pend_q & ~gnt_clr);
            if (tiles_rom_req) tiles_addr_q <= tiles_rom_addr;
            if (spr_rom_req)   spr_addr_q   <= spr_rom_addr;
            if (m68k_rom_req)  m68k_addr_q  <= m68k_rom_addr;
            if (theme_rom_req) theme_addr_q <= theme_rom_addr;
        end
    end

    // Transaction FSM: grant, hold the SDRAM request until accepted, deliver on data strobe.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            gnt_q        <= CH_TILES;
            hi_q         <= 1'b0;
            sd_req_q     <= 1'b0;
            sd_addr_q    <= 26'd0;
            m68k_busy_q  <= 1'b0;
            m68k_dout_q  <= 16'd0;
            tiles_dout_q <= 32'd0;
            spr_dout_q   <= 32'd0;
            theme_dout_q <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_fire) begin
                        gnt_q     <= gnt_sel;
                        hi_q      <= m68k_addr_q[0];
                        sd_addr_q <= gnt_addr;
                        sd_req_q  <= 1'b1;
                        if (gnt_sel == CH_M68K) m68k_busy_q <= 1'b1;
                        state_q   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (sd_ack) begin
                        sd_req_q <= 1'b0;
                        state_q  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (sd_valid) begin
                        case (gnt_q)
                            CH_TILES: tiles_dout_q <= sd_data;
                            CH_SPR:   spr_dout_q   <= sd_data;
                            CH_M68K: begin
                                m68k_dout_q <= hi_q ? sd_data[31:16] : sd_data[15:0];
                                m68k_busy_q <= 1'b0;
                            end
                            default:  theme_dout_q <= sd_data;
                        endcase
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign sd_req         = sd_req_q;
    assign sd_addr        = sd_addr_q;
    assign m68k_rom_dout  = m68k_dout_q;
    assign tiles_rom_dout = tiles_dout_q;
    assign spr_rom_dout   = spr_dout_q;
    assign theme_rom_dout = theme_dout_q;
    assign sdram_dtack    = ~(m68k_rom_req | pend_q[CH_M68K] | m68k_busy_q);

`ifdef ROM_SRV_STATS_EN
    logic [3:0]  ovr_q;
    logic [15:0] maxlat_q, lat_t_q, lat_s_q, lat_cand;
    logic [3:0]  dlv;
    logic        act_t, act_s;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign dlv      = (state_q == S_WAIT && sd_valid) ? (4'b0001 << gnt_q) : 4'b0000;
    assign act_t    = pend_q[CH_TILES] || (state_q != S_IDLE && gnt_q == CH_TILES);
    assign act_s    = pend_q[CH_SPR]   || (state_q != S_IDLE && gnt_q == CH_SPR);
    assign lat_cand = dlv[CH_TILES] ? sat_inc(lat_t_q) :
                      dlv[CH_SPR]   ? sat_inc(lat_s_q) : 16'd0;

    // Sticky overrun flags and the worst video request-to-delivery latency.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ovr_q    <= 4'd0;
            maxlat_q <= 16'd0;
            lat_t_q  <= 16'd0;
            lat_s_q  <= 16'd0;
        end else begin
            ovr_q <= ovr_q | (req_v & pend_q);
            if (lat_cand > maxlat_q) maxlat_q <= lat_cand;
            lat_t_q <= (dlv[CH_TILES] || !act_t) ? 16'd0 : sat_inc(lat_t_q);
            lat_s_q <= (dlv[CH_SPR]   || !act_s) ? 16'd0 : sat_inc(lat_s_q);
        end
    end

    assign stat_overrun = ovr_q;
    assign stat_maxlat  = maxlat_q;
`endif

endmodule
